// File: rtl/ysyx_23060332_lsu_if.sv
// Memory request/response bus between the LSU (master) and the memory system (slave).
interface ysyx_23060332_lsu_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_resp_valid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_req_ready, bus_resp_valid, bus_rdata
    );

    modport slave (
        input  bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_req_ready, bus_resp_valid, bus_rdata
    );
endinterface

// File: rtl/ysyx_23060332_lsu.sv
// Load/store stage: one EXU result per transaction, variable-latency memory bus, write-back handshake.
// Optional misaligned-access detection is enabled by defining LSU_MISALIGN_CHK_EN.
module ysyx_23060332_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mem_ren_i,
    input  logic        mem_wen_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] st_data_i,
    input  logic [7:0]  wmask_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] alu_i,
    input  logic [4:0]  waddr_i,
    input  logic        reg_wen_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  waddr_o,
    output logic        reg_wen_o,
    output logic [31:0] wdata_o,
    output logic        bus_err_o,
    output logic        misalign_o,
    ysyx_23060332_lsu_if.master bus
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_t;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]      r_waddr;
    logic            r_reg_wen;
    logic            r_load;
    logic [2:0]      r_func3;
    logic [1:0]      r_addr_lo;
    logic            mis_c;
    logic [31:0]     shifted_c;
    logic [31:0]     ld_data_c;
    logic            unused_c;

    assign unused_c = &{1'b0, wmask_i[7:4]};

`ifdef LSU_MISALIGN_CHK_EN
    // Half/word alignment judged from either the load width or the store mask.
    assign mis_c = (mem_ren_i | mem_wen_i) &&
                   (((func3_i[1:0] == 2'b01 || wmask_i == 8'h03) && addr_i[0]) ||
                    ((func3_i[1:0] == 2'b10 || wmask_i == 8'h0F) && addr_i[1:0] != 2'b00));
`else
    assign mis_c = 1'b0;
`endif

    // Load data formatting from the captured byte offset and width.
    always_comb begin
        shifted_c = bus.bus_rdata >> {r_addr_lo, 3'b000};
        ld_data_c = shifted_c;
        case (r_func3)
            3'b000:  ld_data_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
            3'b001:  ld_data_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
            3'b100:  ld_data_c = {24'h0, shifted_c[7:0]};
            3'b101:  ld_data_c = {16'h0, shifted_c[15:0]};
            default: ld_data_c = shifted_c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= '0;
            in_ready          <= 1'b1;
            out_valid         <= 1'b0;
            waddr_o           <= '0;
            reg_wen_o         <= 1'b0;
            wdata_o           <= '0;
            bus_err_o         <= 1'b0;
            misalign_o        <= 1'b0;
            bus.bus_req_valid <= 1'b0;
            bus.bus_we        <= 1'b0;
            bus.bus_addr      <= '0;
            bus.bus_wdata     <= '0;
            bus.bus_wstrb     <= '0;
            r_waddr           <= '0;
            r_reg_wen         <= 1'b0;
            r_load            <= 1'b0;
            r_func3           <= '0;
            r_addr_lo         <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    in_ready      <= 1'b0;
                    r_waddr       <= waddr_i;
                    r_reg_wen     <= reg_wen_i;
                    r_load        <= mem_ren_i & ~mem_wen_i;
                    r_func3       <= func3_i;
                    r_addr_lo     <= addr_i[1:0];
                    bus.bus_we    <= mem_wen_i;
                    bus.bus_addr  <= {addr_i[31:2], 2'b00};
                    bus.bus_wdata <= st_data_i << {addr_i[1:0], 3'b000};
                    bus.bus_wstrb <= 4'(wmask_i[3:0] << addr_i[1:0]);
                    if (mis_c) begin
                        state      <= OUT;
                        out_valid  <= 1'b1;
                        misalign_o <= 1'b1;
                        reg_wen_o  <= 1'b0;
                        waddr_o    <= waddr_i;
                        wdata_o    <= '0;
                    end else if (!mem_ren_i && !mem_wen_i) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        reg_wen_o <= reg_wen_i;
                        waddr_o   <= waddr_i;
                        wdata_o   <= alu_i;
                    end else begin
                        state             <= REQ;
                        bus.bus_req_valid <= 1'b1;
                    end
                end
                REQ: if (bus.bus_req_ready) begin
                    state             <= RESP;
                    bus.bus_req_valid <= 1'b0;
                    cnt               <= '0;
                end
                RESP: begin
                    if (bus.bus_resp_valid) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        reg_wen_o <= r_reg_wen;
                        waddr_o   <= r_waddr;
                        wdata_o   <= r_load ? ld_data_c : 32'h0;
                    end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        bus_err_o <= 1'b1;
                        reg_wen_o <= 1'b0;
                        waddr_o   <= r_waddr;
                        wdata_o   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                OUT: if (out_ready) begin
                    state      <= IDLE;
                    out_valid  <= 1'b0;
                    in_ready   <= 1'b1;
                    bus_err_o  <= 1'b0;
                    misalign_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Directed bench for ysyx_23060332_lsu; timeout parameter shrunk to 4 cycles.
module tb_ysyx_23060332_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic        mem_ren_i, mem_wen_i;
    logic [31:0] addr_i, st_data_i, alu_i;
    logic [7:0]  wmask_i;
    logic [2:0]  func3_i;
    logic [4:0]  waddr_i;
    logic        reg_wen_i;
    logic        out_valid, out_ready;
    logic [4:0]  waddr_o;
    logic        reg_wen_o;
    logic [31:0] wdata_o;
    logic        bus_err_o, misalign_o;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_23060332_lsu_if bus_if ();

    ysyx_23060332_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem_ren_i(mem_ren_i), .mem_wen_i(mem_wen_i),
        .addr_i(addr_i), .st_data_i(st_data_i), .wmask_i(wmask_i),
        .func3_i(func3_i), .alu_i(alu_i), .waddr_i(waddr_i), .reg_wen_i(reg_wen_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .waddr_o(waddr_o), .reg_wen_o(reg_wen_o), .wdata_o(wdata_o),
        .bus_err_o(bus_err_o), .misalign_o(misalign_o),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic ren, input logic wen, input logic [31:0] addr,
                         input logic [31:0] st, input logic [7:0] wm, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [4:0] rd, input logic rwen);
        chk("in_ready_before_issue", 32'(in_ready), 32'd1);
        mem_ren_i = ren; mem_wen_i = wen; addr_i = addr; st_data_i = st;
        wmask_i = wm; func3_i = f3; alu_i = alu; waddr_i = rd; reg_wen_i = rwen;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic finish_out(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_out_valid_clr"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
        chk({tag, "_err_clr"}, 32'(bus_err_o), 32'd0);
    endtask

    // Zero-wait load: handshake on the cycle after accept, response one cycle later.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [31:0] exp);
        issue(1'b1, 1'b0, addr, 32'h0, 8'h0, f3, 32'h0, 5'd7, 1'b1);
        chk({tag, "_req_valid"}, 32'(bus_if.bus_req_valid), 32'd1);
        chk({tag, "_addr"}, bus_if.bus_addr, exp_addr);
        chk({tag, "_we"}, 32'(bus_if.bus_we), 32'd0);
        step();
        chk({tag, "_req_drop"}, 32'(bus_if.bus_req_valid), 32'd0);
        chk({tag, "_not_yet"}, 32'(out_valid), 32'd0);
        bus_if.bus_resp_valid = 1'b1;
        bus_if.bus_rdata = rdata;
        step();
        bus_if.bus_resp_valid = 1'b0;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_wdata"}, wdata_o, exp);
        chk({tag, "_reg_wen"}, 32'(reg_wen_o), 32'd1);
        chk({tag, "_waddr"}, 32'(waddr_o), 32'd7);
        finish_out(tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        mem_ren_i = 1'b0; mem_wen_i = 1'b0; addr_i = '0; st_data_i = '0;
        wmask_i = '0; func3_i = '0; alu_i = '0; waddr_i = '0; reg_wen_i = 1'b0;
        bus_if.bus_req_ready = 1'b1; bus_if.bus_resp_valid = 1'b0; bus_if.bus_rdata = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_req_valid", 32'(bus_if.bus_req_valid), 32'd0);
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_err", 32'(bus_err_o), 32'd0);
        chk("rst_misalign", 32'(misalign_o), 32'd0);

        // Non-memory pass-through, one cycle latency
        issue(1'b0, 1'b0, 32'h0, 32'h0, 8'h0, 3'b000, 32'h1234, 5'd5, 1'b1);
        chk("pt_out_valid", 32'(out_valid), 32'd1);
        chk("pt_wdata", wdata_o, 32'h1234);
        chk("pt_waddr", 32'(waddr_o), 32'd5);
        chk("pt_reg_wen", 32'(reg_wen_o), 32'd1);
        chk("pt_in_ready", 32'(in_ready), 32'd0);
        chk("pt_no_req", 32'(bus_if.bus_req_valid), 32'd0);
        finish_out("pt");
        chk("pt_no_req_after", 32'(bus_if.bus_req_valid), 32'd0);

        // Load formatting
        do_load("lb",    32'h8000_0003, 3'b000, 32'h80FF_0000, 32'h8000_0000, 32'hFFFF_FF80);
        do_load("lbu",   32'h8000_0003, 3'b100, 32'h80FF_0000, 32'h8000_0000, 32'h0000_0080);
        do_load("lh",    32'h8000_0002, 3'b001, 32'h8001_1234, 32'h8000_0000, 32'hFFFF_8001);
        do_load("lhu",   32'h8000_0002, 3'b101, 32'h8001_1234, 32'h8000_0000, 32'h0000_8001);
        do_load("lw",    32'h8000_0004, 3'b010, 32'hDEAD_BEEF, 32'h8000_0004, 32'hDEAD_BEEF);
        do_load("f3_11", 32'h8000_0008, 3'b011, 32'h0BAD_F00D, 32'h8000_0008, 32'h0BAD_F00D);

        // SH at byte offset 2
        issue(1'b0, 1'b1, 32'h8000_0002, 32'h0000_BEEF, 8'h03, 3'b001, 32'h0, 5'd3, 1'b0);
        chk("sh_req_valid", 32'(bus_if.bus_req_valid), 32'd1);
        chk("sh_we", 32'(bus_if.bus_we), 32'd1);
        chk("sh_addr", bus_if.bus_addr, 32'h8000_0000);
        chk("sh_wdata", bus_if.bus_wdata, 32'hBEEF_0000);
        chk("sh_wstrb", 32'(bus_if.bus_wstrb), 32'h0000_000C);
        step();
        bus_if.bus_resp_valid = 1'b1; bus_if.bus_rdata = 32'hFFFF_FFFF;
        step();
        bus_if.bus_resp_valid = 1'b0;
        chk("sh_out_valid", 32'(out_valid), 32'd1);
        chk("sh_reg_wen", 32'(reg_wen_o), 32'd0);
        chk("sh_wdata_o", wdata_o, 32'h0);
        finish_out("sh");

        // ren and wen both set: store takes priority
        issue(1'b1, 1'b1, 32'h8000_0001, 32'h0000_00AB, 8'h01, 3'b000, 32'h0, 5'd4, 1'b0);
        chk("both_we", 32'(bus_if.bus_we), 32'd1);
        chk("both_wdata", bus_if.bus_wdata, 32'h0000_AB00);
        chk("both_wstrb", 32'(bus_if.bus_wstrb), 32'h0000_0002);
        step();
        bus_if.bus_resp_valid = 1'b1; bus_if.bus_rdata = 32'h1234_5678;
        step();
        bus_if.bus_resp_valid = 1'b0;
        chk("both_wdata_o", wdata_o, 32'h0);
        finish_out("both");

        // Request and write-back backpressure
        bus_if.bus_req_ready = 1'b0;
        issue(1'b1, 1'b0, 32'h8000_0010, 32'h0, 8'h0, 3'b010, 32'h0, 5'd9, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_req_valid", 32'(bus_if.bus_req_valid), 32'd1);
            chk("bp_addr", bus_if.bus_addr, 32'h8000_0010);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            if (i == 3) bus_if.bus_req_ready = 1'b1;
            step();
        end
        chk("bp_req_drop", 32'(bus_if.bus_req_valid), 32'd0);
        bus_if.bus_resp_valid = 1'b1; bus_if.bus_rdata = 32'h1122_3344;
        step();
        bus_if.bus_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_out_hold", 32'(out_valid), 32'd1);
            chk("bp_wdata_hold", wdata_o, 32'h1122_3344);
            chk("bp_in_ready_out", 32'(in_ready), 32'd0);
            if (i < 2) step();
        end
        finish_out("bp");

        // Response timeout after four RESP cycles
        issue(1'b1, 1'b0, 32'h8000_0020, 32'h0, 8'h0, 3'b010, 32'h0, 5'd11, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_waiting", 32'(out_valid), 32'd0);
        end
        step();
        chk("to_out_valid", 32'(out_valid), 32'd1);
        chk("to_bus_err", 32'(bus_err_o), 32'd1);
        chk("to_reg_wen", 32'(reg_wen_o), 32'd0);
        chk("to_wdata", wdata_o, 32'h0);
        finish_out("to");

        // Reset while waiting for a response
        issue(1'b1, 1'b0, 32'h8000_0030, 32'h0, 8'h0, 3'b010, 32'h0, 5'd12, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rr_in_ready", 32'(in_ready), 32'd1);
        chk("rr_out_valid", 32'(out_valid), 32'd0);
        chk("rr_req_valid", 32'(bus_if.bus_req_valid), 32'd0);
        chk("rr_waddr", 32'(waddr_o), 32'd0);
        bus_if.bus_resp_valid = 1'b1; bus_if.bus_rdata = 32'hCAFE_BABE;
        step();
        bus_if.bus_resp_valid = 1'b0;
        chk("rr_stray_out", 32'(out_valid), 32'd0);
        chk("rr_stray_wdata", wdata_o, 32'h0);
        chk("rr_stray_in_ready", 32'(in_ready), 32'd1);

        // Reset while the request is pending
        bus_if.bus_req_ready = 1'b0;
        issue(1'b1, 1'b0, 32'h8000_0040, 32'h0, 8'h0, 3'b010, 32'h0, 5'd13, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_if.bus_req_ready = 1'b1;
        chk("rq_req_drop", 32'(bus_if.bus_req_valid), 32'd0);
        chk("rq_in_ready", 32'(in_ready), 32'd1);

        // Misaligned word load
        issue(1'b1, 1'b0, 32'h8000_0001, 32'h0, 8'h0, 3'b010, 32'h0, 5'd14, 1'b1);
`ifdef LSU_MISALIGN_CHK_EN
        chk("mis_out_valid", 32'(out_valid), 32'd1);
        chk("mis_flag", 32'(misalign_o), 32'd1);
        chk("mis_no_req", 32'(bus_if.bus_req_valid), 32'd0);
        chk("mis_reg_wen", 32'(reg_wen_o), 32'd0);
        chk("mis_wdata", wdata_o, 32'h0);
        finish_out("mis");
        chk("mis_flag_clr", 32'(misalign_o), 32'd0);
`else
        chk("mis_req_valid", 32'(bus_if.bus_req_valid), 32'd1);
        chk("mis_addr", bus_if.bus_addr, 32'h8000_0000);
        chk("mis_flag", 32'(misalign_o), 32'd0);
        step();
        bus_if.bus_resp_valid = 1'b1; bus_if.bus_rdata = 32'hAABB_CCDD;
        step();
        bus_if.bus_resp_valid = 1'b0;
        chk("mis_wdata", wdata_o, 32'h00AA_BBCC);
        chk("mis_reg_wen", 32'(reg_wen_o), 32'd1);
        finish_out("mis");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
